mask_centroid_extractor: RTL

// Consumes the 8-bit binary mask stream that the morphology pipeline (erode stage) writes to the destination FIFO.

---
 rtl/mask_centroid_extractor_pkg.sv | 27 ++
 rtl/mask_centroid_extractor_if.sv | 55 +++++
 rtl/mask_centroid_extractor_seq_divider.sv | 89 ++++++++
 rtl/mask_centroid_extractor.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mask_centroid_extractor_pkg.sv
// Shared constants, widths and state encoding for the mask centroid extractor.
// All derived widths follow from the frame geometry so that accumulators never overflow.
package mask_centroid_extractor_pkg;

    localparam int IMG_W     = 30;
    localparam int IMG_H     = 30;
    localparam int FG_THRESH = 128;
    localparam int MIN_AREA  = 4;
    localparam int NPIX      = IMG_W * IMG_H;
    localparam int XW        = $clog2(IMG_W);
    localparam int YW        = $clog2(IMG_H);
    localparam int CW        = $clog2(NPIX + 1);
    localparam int SW        = CW + ((XW > YW) ? XW : YW);
    localparam int WAIT_W    = $clog2(SW + 1);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DIV     = 2'd2,
        ST_OUT     = 2'd3
    } state_t;

    function automatic logic is_fg(input logic [7:0] pix);
        return (pix >= 8'(FG_THRESH));
    endfunction

endpackage

// File: rtl/mask_centroid_extractor_if.sv
// Mask FIFO read port and per-frame result record port of the centroid extractor.
// master = extractor side, slave = FIFO/consumer side.
interface mask_centroid_extractor_if;
    import mask_centroid_extractor_pkg::*;

    logic          mask_rd_en;
    logic [7:0]    mask_dout;
    logic          mask_empty;
    logic          res_valid;
    logic          res_ready;
    logic          res_found;
    logic [CW-1:0] res_count;
    logic [XW-1:0] res_cx;
    logic [YW-1:0] res_cy;
    logic [XW-1:0] res_xmin;
    logic [XW-1:0] res_xmax;
    logic [YW-1:0] res_ymin;
    logic [YW-1:0] res_ymax;
    logic [15:0]   res_frame_id;

    modport master (
        output mask_rd_en,
        input  mask_dout,
        input  mask_empty,
        output res_valid,
        input  res_ready,
        output res_found,
        output res_count,
        output res_cx,
        output res_cy,
        output res_xmin,
        output res_xmax,
        output res_ymin,
        output res_ymax,
        output res_frame_id
    );

    modport slave (
        input  mask_rd_en,
        output mask_dout,
        output mask_empty,
        input  res_valid,
        output res_ready,
        input  res_found,
        input  res_count,
        input  res_cx,
        input  res_cy,
        input  res_xmin,
        input  res_xmax,
        input  res_ymin,
        input  res_ymax,
        input  res_frame_id
    );

endinterface

// File: rtl/mask_centroid_extractor_seq_divider.sv
// Restoring unsigned divider: quotient = floor(num/den) after exactly W cycles.
// The first quotient bit is resolved on the start edge, so done is high W cycles after start.
module seq_divider #(
    parameter int W = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] num,
    input  logic [W-1:0] den,
    output logic [W-1:0] quo,
    output logic         done
);

    localparam int CNT_W = $clog2(W + 1);

    typedef struct packed {
        logic [W-1:0] rem;
        logic [W-1:0] quo;
    } div_st_t;

    // One restoring step; remainder stays below den so it fits in W bits.
    function automatic div_st_t div_step(input logic [W-1:0] rem,
                                         input logic [W-1:0] q,
                                         input logic [W-1:0] d);
        logic [W:0] sh;
        logic [W:0] df;
        div_st_t    r;
        sh = {rem, q[W-1]};
        df = sh - {1'b0, d};
        if (df[W]) begin
            r.rem = sh[W-1:0];
            r.quo = {q[W-2:0], 1'b0};
        end else begin
            r.rem = df[W-1:0];
            r.quo = {q[W-2:0], 1'b1};
        end
        return r;
    endfunction

    div_st_t          st_r;
    div_st_t          step_s;
    logic [W-1:0]     den_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             done_r;

    // Next partial remainder/quotient from either fresh operands or the running state
    always_comb begin
        if (start) begin
            step_s = div_step({W{1'b0}}, num, den);
        end else begin
            step_s = div_step(st_r.rem, st_r.quo, den_r);
        end
    end

    // Iteration state, step counter and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            st_r   <= {(2 * W){1'b0}};
            den_r  <= {W{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (start) begin
            st_r   <= step_s;
            den_r  <= den;
            cnt_r  <= CNT_W'(1);
            busy_r <= 1'b1;
            done_r <= 1'b0;
        end else if (busy_r) begin
            st_r  <= step_s;
            cnt_r <= cnt_r + CNT_W'(1);
            if (cnt_r == CNT_W'(W - 1)) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end else begin
                busy_r <= 1'b1;
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign quo  = st_r.quo;
    assign done = done_r;

endmodule

// File: rtl/mask_centroid_extractor.sv
// Reads one binary-mask frame from a FIFO, accumulates area, coordinate sums and bbox,
// divides for the centroid and offers one result record per frame on a valid/ready port.
module mask_centroid_extractor
    import mask_centroid_extractor_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    mask_centroid_extractor_if.master  bus
);

    state_t            state_r;
    state_t            state_nx;
    logic              rd_en_s;
    logic              div_start_s;
    logic              div_finish_s;
    logic              finish_s;
    logic              handshake_s;
    logic              rd_pend_r;
    logic [WAIT_W-1:0] wait_r;
    logic [CW-1:0]     issued_r;
    logic [XW-1:0]     x_r;
    logic [YW-1:0]     y_r;
    logic [CW-1:0]     count_r;
    logic [SW-1:0]     sumx_r;
    logic [SW-1:0]     sumy_r;
    logic [XW-1:0]     xmin_r;
    logic [XW-1:0]     xmax_r;
    logic [YW-1:0]     ymin_r;
    logic [YW-1:0]     ymax_r;
    logic [SW-1:0]     den_s;
    logic [SW-1:0]     qx_s;
    logic [SW-1:0]     qy_s;
    logic              donex_s;
    logic              doney_s;
    logic [XW-1:0]     cx_s;
    logic [YW-1:0]     cy_s;
    logic              found_s;
    logic              res_valid_r;
    logic              res_found_r;
    logic [CW-1:0]     res_count_r;
    logic [XW-1:0]     res_cx_r;
    logic [YW-1:0]     res_cy_r;
    logic [XW-1:0]     res_xmin_r;
    logic [XW-1:0]     res_xmax_r;
    logic [YW-1:0]     res_ymin_r;
    logic [YW-1:0]     res_ymax_r;
    logic [15:0]       frame_id_r;

    // Next-state, FIFO read strobe and divider kick-off
    always_comb begin
        state_nx    = state_r;
        rd_en_s     = 1'b0;
        div_start_s = 1'b0;
        case (state_r)
            ST_COLLECT: begin
                rd_en_s = !rst && !bus.mask_empty && (issued_r < CW'(NPIX));
                if (rd_en_s && (issued_r == CW'(NPIX - 1))) begin
                    state_nx = ST_DRAIN;
                end else begin
                    state_nx = ST_COLLECT;
                end
            end
            ST_DRAIN: begin
                state_nx = ST_DIV;
            end
            ST_DIV: begin
                div_start_s = (wait_r == {WAIT_W{1'b0}}) && (count_r != {CW{1'b0}});
                if (div_finish_s) begin
                    state_nx = ST_OUT;
                end else begin
                    state_nx = ST_DIV;
                end
            end
            ST_OUT: begin
                if (bus.res_ready) begin
                    state_nx = ST_COLLECT;
                end else begin
                    state_nx = ST_OUT;
                end
            end
            default: begin
                state_nx = ST_COLLECT;
            end
        endcase
    end

    // An empty frame skips the dividers but waits the same SW cycles to keep timing fixed.
    assign div_finish_s = (count_r == {CW{1'b0}}) ? (wait_r == WAIT_W'(SW)) : (donex_s && doney_s);
    assign finish_s     = (state_r == ST_DIV) && div_finish_s;
    assign handshake_s  = (state_r == ST_OUT) && res_valid_r && bus.res_ready;

    // State register, read-pending flag and DIV-phase cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_COLLECT;
            rd_pend_r <= 1'b0;
            wait_r    <= {WAIT_W{1'b0}};
        end else begin
            state_r   <= state_nx;
            rd_pend_r <= rd_en_s;
            if (state_r == ST_DIV) begin
                wait_r <= wait_r + WAIT_W'(1);
            end else begin
                wait_r <= {WAIT_W{1'b0}};
            end
        end
    end

    // Raster position, read issue count and foreground accumulators
    always_ff @(posedge clk) begin
        if (rst || handshake_s) begin
            issued_r <= {CW{1'b0}};
            x_r      <= {XW{1'b0}};
            y_r      <= {YW{1'b0}};
            count_r  <= {CW{1'b0}};
            sumx_r   <= {SW{1'b0}};
            sumy_r   <= {SW{1'b0}};
            xmin_r   <= {XW{1'b1}};
            xmax_r   <= {XW{1'b0}};
            ymin_r   <= {YW{1'b1}};
            ymax_r   <= {YW{1'b0}};
        end else begin
            if (rd_en_s) begin
                issued_r <= issued_r + CW'(1);
            end
            if (rd_pend_r) begin
                if (is_fg(bus.mask_dout)) begin
                    count_r <= count_r + CW'(1);
                    sumx_r  <= sumx_r + SW'(x_r);
                    sumy_r  <= sumy_r + SW'(y_r);
                    if (x_r < xmin_r) xmin_r <= x_r;
                    if (x_r > xmax_r) xmax_r <= x_r;
                    if (y_r < ymin_r) ymin_r <= y_r;
                    if (y_r > ymax_r) ymax_r <= y_r;
                end
                if (x_r == XW'(IMG_W - 1)) begin
                    x_r <= {XW{1'b0}};
                    y_r <= y_r + YW'(1);
                end else begin
                    x_r <= x_r + XW'(1);
                end
            end
        end
    end

    assign den_s = SW'(count_r);

    seq_divider #(.W(SW)) u_div_x (
        .clk   (clk),
        .rst   (rst),
        .start (div_start_s),
        .num   (sumx_r),
        .den   (den_s),
        .quo   (qx_s),
        .done  (donex_s)
    );

    seq_divider #(.W(SW)) u_div_y (
        .clk   (clk),
        .rst   (rst),
        .start (div_start_s),
        .num   (sumy_r),
        .den   (den_s),
        .quo   (qy_s),
        .done  (doney_s)
    );

    // Quotient cannot exceed the largest coordinate; saturate rather than wrap if it ever did.
    assign cx_s    = (|qx_s[SW-1:XW]) ? {XW{1'b1}} : qx_s[XW-1:0];
    assign cy_s    = (|qy_s[SW-1:YW]) ? {YW{1'b1}} : qy_s[YW-1:0];
    assign found_s = (count_r >= CW'(MIN_AREA));

    // Result record capture, handshake release and frame counter
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_r <= 1'b0;
            res_found_r <= 1'b0;
            res_count_r <= {CW{1'b0}};
            res_cx_r    <= {XW{1'b0}};
            res_cy_r    <= {YW{1'b0}};
            res_xmin_r  <= {XW{1'b0}};
            res_xmax_r  <= {XW{1'b0}};
            res_ymin_r  <= {YW{1'b0}};
            res_ymax_r  <= {YW{1'b0}};
            frame_id_r  <= 16'd0;
        end else if (finish_s) begin
            res_valid_r <= 1'b1;
            res_found_r <= found_s;
            res_count_r <= count_r;
            res_cx_r    <= (count_r == {CW{1'b0}}) ? {XW{1'b0}} : cx_s;
            res_cy_r    <= (count_r == {CW{1'b0}}) ? {YW{1'b0}} : cy_s;
            res_xmin_r  <= found_s ? xmin_r : {XW{1'b0}};
            res_xmax_r  <= found_s ? xmax_r : {XW{1'b0}};
            res_ymin_r  <= found_s ? ymin_r : {YW{1'b0}};
            res_ymax_r  <= found_s ? ymax_r : {YW{1'b0}};
        end else if (handshake_s) begin
            res_valid_r <= 1'b0;
            frame_id_r  <= frame_id_r + 16'd1;
        end
    end

    assign bus.mask_rd_en   = rd_en_s;
    assign bus.res_valid    = res_valid_r;
    assign bus.res_found    = res_found_r;
    assign bus.res_count    = res_count_r;
    assign bus.res_cx       = res_cx_r;
    assign bus.res_cy       = res_cy_r;
    assign bus.res_xmin     = res_xmin_r;
    assign bus.res_xmax     = res_xmax_r;
    assign bus.res_ymin     = res_ymin_r;
    assign bus.res_ymax     = res_ymax_r;
    assign bus.res_frame_id = frame_id_r;

endmodule
